// File: rtl/lcd1602_multifield_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd1602_multifield_ctrl
//  Description : HD44780 / LCD1602 8-bit bus driver. Runs the power-up init,
//                paints a 32-char static text buffer, then refreshes
//                NUM_FIELDS live 2-digit decimal fields at runtime positions.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd1602_multifield_ctrl #(
    parameter int TICK_CYCLES     = 50000,
    parameter int INIT_WAIT_TICKS = 20,
    parameter int NUM_FIELDS      = 4,
    parameter int DATA_BITS       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    txt_we,
    input  logic [4:0]              txt_addr,
    input  logic [7:0]              txt_data,
    input  logic [7*NUM_FIELDS-1:0] field_val,
    input  logic [5*NUM_FIELDS-1:0] field_pos,
    input  logic                    redraw_i,
    output logic                    rs,
    output logic                    rw,
    output logic                    enable,
    output logic [DATA_BITS-1:0]    data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int C_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int C_WAIT_W = (INIT_WAIT_TICKS > 1) ? $clog2(INIT_WAIT_TICKS) : 1;
    localparam int C_FLD_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_CYCLES - 1);
    localparam logic [C_TICK_W-1:0] C_E_RISE    = C_TICK_W'(TICK_CYCLES / 4);
    localparam logic [C_TICK_W-1:0] C_E_FALL    = C_TICK_W'((3 * TICK_CYCLES) / 4);
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(INIT_WAIT_TICKS - 1);
    localparam logic [C_FLD_W-1:0]  C_FLD_LAST  = C_FLD_W'(NUM_FIELDS - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WAIT  = 4'd1,
        S_INIT  = 4'd2,
        S_ADDR1 = 4'd3,
        S_TEXT1 = 4'd4,
        S_ADDR2 = 4'd5,
        S_TEXT2 = 4'd6,
        S_FADDR = 4'd7,
        S_FHI   = 4'd8,
        S_FLO   = 4'd9
    } state_t;

    state_t                r_state;
    logic [C_TICK_W-1:0]   r_tick;
    logic [C_WAIT_W-1:0]   r_wait;
    logic [3:0]            r_step;
    logic [C_FLD_W-1:0]    r_fld;
    logic                  r_emit;
    logic                  r_redraw;
    logic [7:0]            r_txt      [32];
    logic [6:0]            r_snap_val [NUM_FIELDS];
    logic [4:0]            r_snap_pos [NUM_FIELDS];

    logic [C_TICK_W-1:0]   w_tick_next;
    logic                  w_step_emit;
    logic                  w_emit_next;
    logic [6:0]            w_val;
    logic [4:0]            w_pos;
    logic [15:0]           w_digits;

    // ASCII tens/units of a field value; out-of-range values show as "--"
    function automatic logic [15:0] to_digits(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] units;
        if (v > 7'd99) begin
            return 16'h2D2D;
        end
        tens  = v / 7'd10;
        units = v - tens * 7'd10;
        return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, units}};
    endfunction

    assign rw = 1'b0;

    // Step pacing, whether the current step drives an E pulse, and field digit lookup
    always_comb begin
        w_tick_next = '0;
        if (r_state != S_IDLE && r_tick != C_TICK_LAST) begin
            w_tick_next = r_tick + 1'b1;
        end
        case (r_state)
            S_IDLE, S_WAIT: w_step_emit = 1'b0;
            S_INIT:         w_step_emit = (r_step < 4'd4);
            default:        w_step_emit = 1'b1;
        endcase
        w_emit_next = (r_state != S_IDLE && r_tick == '0) ? w_step_emit : r_emit;
        w_val       = r_snap_val[r_fld];
        w_pos       = r_snap_pos[r_fld];
        w_digits    = to_digits(w_val);
    end

    // Static text buffer; a write lands next clk so a same-cycle read sees the old char
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_txt[i] <= 8'h20;
            end
        end else if (txt_we) begin
            r_txt[txt_addr] <= txt_data;
        end
    end

    // Main sequencer: one state action per step, executed on the tick_cnt==0 cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_wait     <= '0;
            r_step     <= '0;
            r_fld      <= '0;
            r_emit     <= 1'b0;
            r_redraw   <= 1'b0;
            rs         <= 1'b0;
            enable     <= 1'b0;
            data       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                r_snap_val[i] <= '0;
                r_snap_pos[i] <= '0;
            end
        end else begin
            r_tick     <= w_tick_next;
            r_emit     <= w_emit_next;
            enable     <= w_emit_next && (w_tick_next >= C_E_RISE) && (w_tick_next < C_E_FALL);
            frame_done <= 1'b0;

            if (r_state == S_IDLE) begin
                if (start_i) begin
                    r_state <= S_WAIT;
                    r_wait  <= '0;
                    busy    <= 1'b1;
                end
            end else if (r_tick == '0) begin
                case (r_state)
                    S_WAIT: begin
                        if (r_wait == C_WAIT_LAST) begin
                            r_state <= S_INIT;
                            r_step  <= '0;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                    S_INIT: begin
                        rs <= 1'b0;
                        case (r_step)
                            4'd0:    data <= DATA_BITS'(8'h38);
                            4'd1:    data <= DATA_BITS'(8'h06);
                            4'd2:    data <= DATA_BITS'(8'h0C);
                            4'd3:    data <= DATA_BITS'(8'h01);
                            default: data <= data;
                        endcase
                        // step 4 is the silent clear-display settling step
                        if (r_step == 4'd4) begin
                            r_state <= S_ADDR1;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                    S_ADDR1: begin
                        rs      <= 1'b0;
                        data    <= DATA_BITS'(8'h80);
                        r_state <= S_TEXT1;
                        r_step  <= '0;
                    end
                    S_TEXT1: begin
                        rs     <= 1'b1;
                        data   <= DATA_BITS'(r_txt[{1'b0, r_step}]);
                        r_step <= r_step + 1'b1;
                        if (r_step == 4'd15) begin
                            r_state <= S_ADDR2;
                        end
                    end
                    S_ADDR2: begin
                        rs      <= 1'b0;
                        data    <= DATA_BITS'(8'hC0);
                        r_state <= S_TEXT2;
                        r_step  <= '0;
                    end
                    S_TEXT2: begin
                        rs     <= 1'b1;
                        data   <= DATA_BITS'(r_txt[{1'b1, r_step}]);
                        r_step <= r_step + 1'b1;
                        if (r_step == 4'd15) begin
                            r_state <= S_FADDR;
                            r_fld   <= '0;
                            for (int i = 0; i < NUM_FIELDS; i++) begin
                                r_snap_val[i] <= field_val[7*i +: 7];
                                r_snap_pos[i] <= field_pos[5*i +: 5];
                            end
                        end
                    end
                    S_FADDR: begin
                        rs      <= 1'b0;
                        data    <= DATA_BITS'({1'b1, w_pos[4], 2'b00, w_pos[3:0]});
                        r_state <= S_FHI;
                    end
                    S_FHI: begin
                        rs      <= 1'b1;
                        data    <= DATA_BITS'(w_digits[15:8]);
                        r_state <= S_FLO;
                    end
                    S_FLO: begin
                        rs   <= 1'b1;
                        data <= DATA_BITS'(w_digits[7:0]);
                        if (r_fld == C_FLD_LAST) begin
                            frame_done <= 1'b1;
                            if (r_redraw) begin
                                r_redraw <= 1'b0;
                                r_state  <= S_ADDR1;
                            end else begin
                                r_state <= S_FADDR;
                                r_fld   <= '0;
                                for (int i = 0; i < NUM_FIELDS; i++) begin
                                    r_snap_val[i] <= field_val[7*i +: 7];
                                    r_snap_pos[i] <= field_pos[5*i +: 5];
                                end
                            end
                        end else begin
                            r_fld   <= r_fld + 1'b1;
                            r_state <= S_FADDR;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // a redraw request arriving on the cycle the pending flag is consumed is kept
            if (redraw_i && r_state != S_IDLE && r_state != S_WAIT && r_state != S_INIT) begin
                r_redraw <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
